// File: rtl/pool2x2_if.sv
// Stream interface for the 2x2 pooling stage: conv result samples in, pooled samples out.
interface pool2x2_if;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               frame_done;

  modport master (output in_data, in_valid, input out_data, out_valid, frame_done);
  modport slave  (input in_data, in_valid, output out_data, out_valid, frame_done);
endinterface

// File: rtl/pool2x2.sv
// Streaming 2x2 stride-2 pooling over a row-major MAP x MAP map (MAP = SIZE-2), one line buffer.
// POOL_AVG_EN selects average pooling; default is signed max pooling.
module pool2x2 #(
  parameter int unsigned SIZE = 7,
  parameter int unsigned MAXW = 8
) (
  input logic       clk,
  input logic       rst_n,
  pool2x2_if.slave  bus
);

  localparam int unsigned MAP      = SIZE - 2;
  localparam int unsigned HALF     = MAP / 2;
  localparam int unsigned LB_DEPTH = (HALF > 0) ? HALF : 1;
  localparam int unsigned IDXW     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
`ifdef POOL_AVG_EN
  localparam int unsigned PW       = 17;
`else
  localparam int unsigned PW       = 16;
`endif

  logic [MAXW-1:0]        row;
  logic [MAXW-1:0]        col;
  logic signed [15:0]     pair_reg;
  logic signed [PW-1:0]   line_buf [LB_DEPTH];

  logic [IDXW-1:0]        lb_idx_c;
  logic                   last_col_c;
  logic                   last_row_c;
  logic                   pool_row_c;
  logic signed [PW-1:0]   pair_c;
  logic signed [15:0]     window_c;
`ifdef POOL_AVG_EN
  logic signed [17:0]     window_sum_c;
`endif

  // Position decode and horizontal/vertical combine of the current window
  always_comb begin
    lb_idx_c   = IDXW'(col >> 1);
    last_col_c = (col == MAXW'(MAP - 1));
    last_row_c = (row == MAXW'(MAP - 1));
    pool_row_c = (row < MAXW'(2 * HALF));
`ifdef POOL_AVG_EN
    pair_c       = {pair_reg[15], pair_reg} + {bus.in_data[15], bus.in_data};
    window_sum_c = {line_buf[lb_idx_c][PW-1], line_buf[lb_idx_c]} + {pair_c[PW-1], pair_c};
    // Arithmetic shift by 2 floors toward -inf
    window_c     = window_sum_c[17:2];
`else
    pair_c   = (bus.in_data > pair_reg) ? bus.in_data : pair_reg;
    window_c = (line_buf[lb_idx_c] > pair_c) ? line_buf[lb_idx_c] : pair_c;
`endif
  end

  // Counters, pair register, line buffer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row            <= '0;
      col            <= '0;
      pair_reg       <= '0;
      bus.out_data   <= '0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      for (int i = 0; i < int'(LB_DEPTH); i++) line_buf[i] <= '0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.in_valid) begin
        if (last_col_c) begin
          col <= '0;
          row <= last_row_c ? '0 : row + MAXW'(1);
        end else begin
          col <= col + MAXW'(1);
        end
        bus.frame_done <= last_col_c && last_row_c;

        // Odd col always lies inside a window; trailing odd-MAP column lands here harmlessly
        if (!col[0]) begin
          pair_reg <= bus.in_data;
        end else if (pool_row_c) begin
          if (!row[0]) begin
            line_buf[lb_idx_c] <= pair_c;
          end else begin
            bus.out_data  <= window_c;
            bus.out_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
